dsp_tx_glue_mc: RTL
===================

Name: dsp_tx_glue_mc

Overview:
Parametrised successor to the per-DSP TX glue. It sits between the baseband sample source, the DUC chain and the TX frontend. Runtime modes are selected through the settings bus: passthrough, I/Q swap, constant IQ, and a ramp test pattern, plus optional saturating spectral inversion on the frontend path. Mode changes are applied glitch-free on a sample boundary, and a strobe counter on debug gives bring-up visibility.

Parameters:
DSPNO, 0, DSP unit number; only selects the debug tag in debug[31:28].
WIDTH, 24, frontend/DUC-output bus width per rail; legal range 16..32.
BASE, 0, settings-bus base address; the block decodes BASE+0..BASE+2.
SAMP_W, 16, baseband rail width; duc_in_sample and bb_sample are {I,Q} at 2*SAMP_W.

Ports:
clock  in  1  system clock.
reset  in  1  asynchronous, active-high reset.
clear  in  1  synchronous clear of counter, ramp and pending mode.
enable  in  1  DSP enable.
set_stb  in  1  settings write strobe.
set_addr  in  8  settings address.
set_data  in  32  settings data.
frontend_i  out  WIDTH  I rail to TX frontend.
frontend_q  out  WIDTH  Q rail to TX frontend.
duc_out_i  in  WIDTH  I rail from DUC.
duc_out_q  in  WIDTH  Q rail from DUC.
duc_in_sample  out  2*SAMP_W  {I,Q} sample to DUC.
duc_in_strobe  in  1  DUC consumes the sample (backpressure).
duc_in_enable  out  1  DUC enable.
bb_sample  in  2*SAMP_W  {I,Q} baseband sample.
bb_strobe  out  1  baseband sample consumed.
debug  out  32  {DSPNO[3:0], 28-bit strobe count}.

Behaviour:
- Reset: clock and reset ports are named clock and reset; reset is asynchronous, active-high.
- Reset values: all registers 0, giving mode=PASS, invert=0, const=0, ramp=0, count=0. After reset, frontend_i, frontend_q and debug[27:0] are 0 and debug[31:28] is DSPNO[3:0].
- Register BASE+0 (ctrl) is a shadow register. Bits [1:0] select the mode: 0=PASS, 1=SWAP, 2=CONST, 3=RAMP. Bit 2 selects invert.
- Register BASE+1 holds the constant {I16,Q16}. It is written directly and is not shadowed.
- Register BASE+2: any write pulses a counter clear.
- Shadow-to-active transfer: the shadow ctrl copies into the active ctrl on the cycle after a duc_in_strobe. When enable=0 the copy happens on any cycle. A pending flag is set by a write and cleared by the copy.
- If a ctrl write and a copy condition land in the same cycle, the new value is captured into the shadow only. It is applied at the next copy opportunity.
- duc_in_sample is combinational from the active mode:
  - PASS: bb_sample.
  - SWAP: {Q,I} of bb_sample.
  - CONST: the const register.
  - RAMP: {ramp,~ramp}.
- bb_strobe = duc_in_strobe & enable in PASS and SWAP, and 0 in CONST and RAMP, so host data is not drained.
- duc_in_enable = enable.
- ramp is SAMP_W bits and increments on each duc_in_strobe while in RAMP mode. It wraps 0xFFFF→0 and resets to 0 on clear.
- Frontend path has exactly 1 cycle of latency. frontend_i <= duc_out_i every cycle.
- frontend_q <= invert ? satneg(duc_out_q) : duc_out_q.
- satneg(x) = -x, except the most-negative WIDTH value maps to the most-positive value.
- The frontend registers do not depend on enable.
- count is 28 bits and increments on duc_in_strobe & enable. It saturates at 0x0FFFFFFF and does not wrap.
- clear, or a write to BASE+2, zeroes count. A clear in the same cycle as a strobe also yields 0.
- clear also zeroes ramp and drops a pending shadow (shadow reloads from active). The const register and active mode are unchanged.
- Writes to addresses outside BASE..BASE+2 are ignored.
- Reset asserted mid-operation: all outputs return to their reset values immediately, asynchronously.

Decomposition:
- Package dsp_tx_glue_pkg holds:
  - mode constants MODE_PASS, MODE_SWAP, MODE_CONST, MODE_RAMP;
  - register offsets REG_CTRL=0, REG_CONST=1, REG_CNTCLR=2;
  - ctrl bit positions.
- One sub-module, tx_sat_neg (parametrised by WIDTH, purely combinational), implements satneg.

Test Plan:
- PASS after reset, bb_sample=0x1234ABCD, duc_in_strobe pulsed → duc_in_sample=0x1234ABCD and bb_strobe=1 in the same cycle; debug[27:0]=1.
- Write ctrl=1 (SWAP) while enable=1 with no strobe → output stays 0x1234ABCD. After the next strobe plus one cycle → 0xABCD1234.
- CONST, const=0x7FFF8000, 3 strobes → duc_in_sample=0x7FFF8000 and bb_strobe held 0. Next, RAMP mode with 3 strobes → samples {0,FFFF},{1,FFFE},{2,FFFD}.
- invert=1, WIDTH=24, duc_out_q=0x800000 → frontend_q=0x7FFFFF one cycle later; duc_out_q=0x000005 → 0xFFFFFB.
- Preload count=0x0FFFFFFE via a forced test hook, then 3 strobes → stays 0x0FFFFFFF. Clear together with a strobe → 0. Write BASE+2 → 0.
- Assert reset asynchronously mid-RAMP (between clock edges) → frontend_i/q=0 and mode=PASS immediately; the first strobe after release passes bb_sample.

Source files
------------

// File: rtl/dsp_tx_glue_pkg.sv
// Shared definitions for the DSP TX glue block.
// Holds the runtime mode encoding, the settings-register offsets relative to
// BASE, the ctrl-register bit layout and the strobe counter width.
package dsp_tx_glue_pkg;

  typedef enum logic [1:0] {
    MODE_PASS  = 2'd0,
    MODE_SWAP  = 2'd1,
    MODE_CONST = 2'd2,
    MODE_RAMP  = 2'd3
  } mode_t;

  // Register offsets relative to BASE.
  localparam int REG_CTRL   = 0;
  localparam int REG_CONST  = 1;
  localparam int REG_CNTCLR = 2;

  // ctrl register bit positions.
  localparam int CTRL_MODE_LSB = 0;
  localparam int CTRL_MODE_MSB = 1;
  localparam int CTRL_INV_BIT  = 2;
  localparam int CTRL_W        = 3;

  localparam int COUNT_W = 28;

  // Active/shadow control word; the packed layout matches set_data[2:0].
  typedef struct packed {
    logic  invert;
    mode_t mode;
  } ctrl_t;

endpackage

// File: rtl/tx_sat_neg.sv
// Saturating two's-complement negation.
// Ports:
//   value    in  WIDTH  operand
//   negated  out WIDTH  -value, with the most-negative code clamped to the
//                       most-positive code (plain negation would overflow)
module tx_sat_neg #(
  parameter int WIDTH = 24
) (
  input  logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] negated
);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MOST_POS = {1'b0, {(WIDTH-1){1'b1}}};

  // Negate, clamping the single overflowing input.
  always_comb begin
    negated = MOST_POS;
    if (value == MOST_NEG) begin
      negated = MOST_POS;
    end else begin
      negated = (~value) + WIDTH'(1'b1);
    end
  end

endmodule

// File: rtl/dsp_tx_glue_mc.sv
// TX glue between the baseband source, the DUC chain and the TX frontend.
// Ports:
//   clock, reset              system clock, asynchronous active-high reset
//   clear                     synchronous clear of counter, ramp, pending ctrl
//   enable                    DSP enable (forwarded as duc_in_enable)
//   set_stb/set_addr/set_data settings bus (BASE+0 ctrl, +1 const, +2 cnt clear)
//   frontend_i/q              registered rails to the TX frontend
//   duc_out_i/q               rails from the DUC
//   duc_in_sample/strobe      {I,Q} sample to the DUC and its consume strobe
//   duc_in_enable             DUC enable
//   bb_sample/bb_strobe       baseband sample and its consume strobe
//   debug                     {DSPNO[3:0], saturating 28-bit strobe count}
module dsp_tx_glue_mc
  import dsp_tx_glue_pkg::*;
#(
  parameter int DSPNO  = 0,
  parameter int WIDTH  = 24,
  parameter int BASE   = 0,
  parameter int SAMP_W = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                clear,
  input  logic                enable,
  input  logic                set_stb,
  input  logic [7:0]          set_addr,
  input  logic [31:0]         set_data,
  output logic [WIDTH-1:0]    frontend_i,
  output logic [WIDTH-1:0]    frontend_q,
  input  logic [WIDTH-1:0]    duc_out_i,
  input  logic [WIDTH-1:0]    duc_out_q,
  output logic [2*SAMP_W-1:0] duc_in_sample,
  input  logic                duc_in_strobe,
  output logic                duc_in_enable,
  input  logic [2*SAMP_W-1:0] bb_sample,
  output logic                bb_strobe,
  output logic [31:0]         debug
);

  localparam logic [7:0]         ADDR_CTRL   = 8'(BASE + REG_CTRL);
  localparam logic [7:0]         ADDR_CONST  = 8'(BASE + REG_CONST);
  localparam logic [7:0]         ADDR_CNTCLR = 8'(BASE + REG_CNTCLR);
  localparam logic [COUNT_W-1:0] COUNT_MAX   = {COUNT_W{1'b1}};
  localparam logic [3:0]         DEBUG_TAG   = 4'(DSPNO);

  ctrl_t               shadow_r;
  ctrl_t               active_r;
  logic                pending_r;
  logic [2*SAMP_W-1:0] const_r;
  logic [SAMP_W-1:0]   ramp_r;
  logic [COUNT_W-1:0]  count_r;
  logic [WIDTH-1:0]    frontend_i_r;
  logic [WIDTH-1:0]    frontend_q_r;

  logic                wr_ctrl_s;
  logic                wr_const_s;
  logic                wr_cntclr_s;
  logic                copy_s;
  logic                count_en_s;
  logic [WIDTH-1:0]    q_neg_s;

  assign wr_ctrl_s   = set_stb & (set_addr == ADDR_CTRL);
  assign wr_const_s  = set_stb & (set_addr == ADDR_CONST);
  assign wr_cntclr_s = set_stb & (set_addr == ADDR_CNTCLR);
  assign count_en_s  = duc_in_strobe & enable;

  // A simultaneous ctrl write wins over the copy: the fresh value stays in
  // the shadow and waits for the next sample boundary. clear drops pending.
  assign copy_s = pending_r & ~wr_ctrl_s & ~clear & (duc_in_strobe | ~enable);

  tx_sat_neg #(.WIDTH(WIDTH)) u_sat_neg (
    .value   (duc_out_q),
    .negated (q_neg_s)
  );

  // Shadow/active ctrl registers and the pending-transfer flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shadow_r  <= ctrl_t'(3'b000);
      active_r  <= ctrl_t'(3'b000);
      pending_r <= 1'b0;
    end else begin
      if (wr_ctrl_s) begin
        shadow_r  <= ctrl_t'(set_data[CTRL_W-1:0]);
        pending_r <= 1'b1;
      end else if (clear) begin
        shadow_r  <= active_r;
        pending_r <= 1'b0;
      end else if (copy_s) begin
        pending_r <= 1'b0;
      end
      if (copy_s) begin
        active_r <= shadow_r;
      end
    end
  end

  // Constant IQ register, written directly (not shadowed).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      const_r <= '0;
    end else if (wr_const_s) begin
      const_r <= set_data[2*SAMP_W-1:0];
    end
  end

  // Ramp pattern generator; advances once per consumed sample in RAMP mode.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ramp_r <= '0;
    end else if (clear) begin
      ramp_r <= '0;
    end else if (duc_in_strobe && (active_r.mode == MODE_RAMP)) begin
      ramp_r <= ramp_r + SAMP_W'(1'b1);
    end
  end

  // Saturating strobe counter; a clear beats a coincident strobe.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_r <= '0;
    end else if (clear || wr_cntclr_s) begin
      count_r <= '0;
    end else if (count_en_s && (count_r != COUNT_MAX)) begin
      count_r <= count_r + COUNT_W'(1'b1);
    end
  end

  // Frontend pipeline stage, independent of enable.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frontend_i_r <= '0;
      frontend_q_r <= '0;
    end else begin
      frontend_i_r <= duc_out_i;
      frontend_q_r <= active_r.invert ? q_neg_s : duc_out_q;
    end
  end

  // Sample mux toward the DUC and baseband consume strobe.
  always_comb begin
    duc_in_sample = bb_sample;
    bb_strobe     = 1'b0;
    case (active_r.mode)
      MODE_PASS: begin
        duc_in_sample = bb_sample;
        bb_strobe     = count_en_s;
      end
      MODE_SWAP: begin
        duc_in_sample = {bb_sample[SAMP_W-1:0], bb_sample[2*SAMP_W-1:SAMP_W]};
        bb_strobe     = count_en_s;
      end
      MODE_CONST: begin
        duc_in_sample = const_r;
        bb_strobe     = 1'b0;
      end
      MODE_RAMP: begin
        duc_in_sample = {ramp_r, ~ramp_r};
        bb_strobe     = 1'b0;
      end
      default: begin
        duc_in_sample = bb_sample;
        bb_strobe     = 1'b0;
      end
    endcase
  end

  assign duc_in_enable = enable;
  assign frontend_i    = frontend_i_r;
  assign frontend_q    = frontend_q_r;
  assign debug         = {DEBUG_TAG, count_r};

endmodule
